// File: rtl/rio_reset_seq_if.sv
// Signal bundle between system reset control and the rio_reset_seq link-reset sequencer.
// The master side drives the requests and the port status; the slave side is the sequencer.
interface rio_reset_seq_if #(
    parameter int CNT_W = 8
);
    logic             link_reset_n;
    logic             port_initialized;
    logic             sys_reset_n;
    logic             lnk_linkreset_n;
    logic             reset_busy;
    logic             timeout_flag;
    logic [CNT_W-1:0] reset_count;

    modport master (
        output link_reset_n,
        output port_initialized,
        input  sys_reset_n,
        input  lnk_linkreset_n,
        input  reset_busy,
        input  timeout_flag,
        input  reset_count
    );

    modport slave (
        input  link_reset_n,
        input  port_initialized,
        output sys_reset_n,
        output lnk_linkreset_n,
        output reset_busy,
        output timeout_flag,
        output reset_count
    );
endinterface

// File: rtl/rio_reset_seq.sv
// SRIO link-reset sequencer: LINKRESET to partner, PHY reset for a set width, hold until released.
// Optional LINKRESET timeout and sticky timeout_flag are built when RIO_RESET_TIMEOUT_EN is defined.
module rio_reset_seq #(
    parameter int TCQ            = 100,
    parameter int PHY_RST_CYCLES = 4,
    parameter int LR_TIMEOUT     = 1024,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 8
) (
    input  logic                  lnk_clk,
    input  logic                  lnk_reset_n,
    rio_reset_seq_if.slave        lnk
);

    localparam int PW = (PHY_RST_CYCLES > 1) ? $clog2(PHY_RST_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        LINKRESET = 4'b0010,
        PHY_RESET = 4'b0100,
        PHY_HOLD  = 4'b1000
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   port_up;
    logic [PW-1:0]          phy_cnt_q, phy_cnt_d;
    logic                   sys_reset_n_q, sys_reset_n_d;
    logic                   lnk_linkreset_n_q, lnk_linkreset_n_d;
    logic                   reset_busy_q, reset_busy_d;
    logic [CNT_W-1:0]       reset_count_q, reset_count_d;
    logic                   unused_params;

    // TCQ only matters to behavioural models; it has no synthesised meaning.
    assign unused_params = (TCQ != 0) ^ (LR_TIMEOUT != 0);

`ifdef RIO_RESET_TIMEOUT_EN
    localparam int TW = $clog2(LR_TIMEOUT);
    logic [TW-1:0] lr_cnt_q, lr_cnt_d;
    logic          timeout_flag_q, timeout_flag_d;
`endif

    assign port_up = sync_q[SYNC_STAGES-1];

    always_ff @(posedge lnk_clk or negedge lnk_reset_n) begin
        if (!lnk_reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lnk.port_initialized};
        end
    end

    always_ff @(posedge lnk_clk or negedge lnk_reset_n) begin
        if (!lnk_reset_n) begin
            state_q           <= IDLE;
            phy_cnt_q         <= '0;
            sys_reset_n_q     <= 1'b1;
            lnk_linkreset_n_q <= 1'b1;
            reset_busy_q      <= 1'b0;
            reset_count_q     <= '0;
        end else begin
            state_q           <= state_d;
            phy_cnt_q         <= phy_cnt_d;
            sys_reset_n_q     <= sys_reset_n_d;
            lnk_linkreset_n_q <= lnk_linkreset_n_d;
            reset_busy_q      <= reset_busy_d;
            reset_count_q     <= reset_count_d;
        end
    end

`ifdef RIO_RESET_TIMEOUT_EN
    always_ff @(posedge lnk_clk or negedge lnk_reset_n) begin
        if (!lnk_reset_n) begin
            lr_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            lr_cnt_q       <= lr_cnt_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        phy_cnt_d     = phy_cnt_q;
        reset_count_d = reset_count_q;
`ifdef RIO_RESET_TIMEOUT_EN
        lr_cnt_d       = lr_cnt_q;
        timeout_flag_d = timeout_flag_q;
`endif
        case (state_q)
            IDLE: begin
                if (!lnk.link_reset_n) begin
                    state_d = LINKRESET;
`ifdef RIO_RESET_TIMEOUT_EN
                    lr_cnt_d       = '0;
                    timeout_flag_d = 1'b0;
`endif
                end
            end
            LINKRESET: begin
                // Port drop is tested first so it wins over a coincident timeout.
                if (!port_up) begin
                    state_d   = PHY_RESET;
                    phy_cnt_d = '0;
                end
`ifdef RIO_RESET_TIMEOUT_EN
                else if (lr_cnt_q == TW'(LR_TIMEOUT - 1)) begin
                    state_d        = PHY_RESET;
                    phy_cnt_d      = '0;
                    timeout_flag_d = 1'b1;
                end else begin
                    lr_cnt_d = lr_cnt_q + 1'b1;
                end
`endif
            end
            PHY_RESET: begin
                if (phy_cnt_q == PW'(PHY_RST_CYCLES - 1)) begin
                    state_d = PHY_HOLD;
                end else begin
                    phy_cnt_d = phy_cnt_q + 1'b1;
                end
            end
            PHY_HOLD: begin
                if (lnk.link_reset_n) begin
                    state_d = IDLE;
                    if (reset_count_q != '1) begin
                        reset_count_d = reset_count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they change with the state register.
        sys_reset_n_d     = !((state_d == PHY_RESET) || (state_d == PHY_HOLD));
        lnk_linkreset_n_d = (state_d != LINKRESET);
        reset_busy_d      = (state_d != IDLE);
    end

    assign lnk.sys_reset_n     = sys_reset_n_q;
    assign lnk.lnk_linkreset_n = lnk_linkreset_n_q;
    assign lnk.reset_busy      = reset_busy_q;
    assign lnk.reset_count     = reset_count_q;
`ifdef RIO_RESET_TIMEOUT_EN
    assign lnk.timeout_flag    = timeout_flag_q;
`else
    assign lnk.timeout_flag    = 1'b0;
`endif

endmodule
